// File: rtl/board_diff.sv
// Board-frame differ: scans a received 9x9 board against the last accepted one,
// one cell per cycle, and reports a single new stone placement, change count and frame error.
module board_diff #(
  parameter int ROWS = 9,
  parameter int COLS = 9,
  localparam int BOARD_W = ROWS * COLS * 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ready_in,
  input  logic [BOARD_W-1:0] board_in,
  output logic               move_valid,
  output logic [3:0]         move_row,
  output logic [3:0]         move_col,
  output logic [1:0]         move_color,
  output logic [6:0]         change_count,
  output logic               frame_err,
  output logic               overrun,
  output logic [BOARD_W-1:0] board_out
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  state_t state, state_nxt;

  logic               ready_last;
  logic [BOARD_W-1:0] cur, prev;
  logic [3:0]         row, col, lat_row, lat_col;
  logic [6:0]         idx, chg_cnt, add_cnt;
  logic [1:0]         lat_color;
  logic               err;
  logic               frame_edge, start, scan_en, report_en, busy, last_cell;
  logic [1:0]         cur_cell, prev_cell;

  assign frame_edge = ready_in && !ready_last;
  assign last_cell  = (row == LAST_ROW) && (col == LAST_COL);
  // idx walks alongside row/col so the cell select needs no divider
  assign cur_cell   = cur[{idx, 1'b0} +: 2];
  assign prev_cell  = prev[{idx, 1'b0} +: 2];
  assign board_out  = prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_edge) state_nxt = SCAN;
      SCAN:    if (last_cell)  state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start     = (state == IDLE) && frame_edge;
    scan_en   = (state == SCAN);
    report_en = (state == REPORT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_last   <= 1'b1;
      cur          <= '0;
      prev         <= '0;
      row          <= '0;
      col          <= '0;
      idx          <= '0;
      chg_cnt      <= '0;
      add_cnt      <= '0;
      err          <= 1'b0;
      lat_row      <= '0;
      lat_col      <= '0;
      lat_color    <= '0;
      move_valid   <= 1'b0;
      move_row     <= '0;
      move_col     <= '0;
      move_color   <= '0;
      change_count <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      ready_last <= ready_in;
      move_valid <= 1'b0;
      overrun    <= busy && frame_edge;
      if (start) begin
        cur     <= board_in;
        chg_cnt <= '0;
        add_cnt <= '0;
        err     <= 1'b0;
        row     <= '0;
        col     <= '0;
        idx     <= '0;
      end
      if (scan_en) begin
        if (cur_cell != prev_cell) chg_cnt <= chg_cnt + 7'd1;
        if (prev_cell == 2'b00 && cur_cell != 2'b00 && cur_cell != 2'b11) begin
          add_cnt   <= add_cnt + 7'd1;
          lat_row   <= row;
          lat_col   <= col;
          lat_color <= cur_cell;
        end
        if (cur_cell == 2'b11) err <= 1'b1;
        idx <= idx + 7'd1;
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
      if (report_en) begin
        change_count <= chg_cnt;
        frame_err    <= err;
        // a frame carrying an invalid code is never accepted as the reference board
        if (!err) prev <= cur;
        if (!err && add_cnt == 7'd1) begin
          move_valid <= 1'b1;
          move_row   <= lat_row;
          move_col   <= lat_col;
          move_color <= lat_color;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_diff.sv
// Self-checking bench for board_diff: directed scenarios plus random frames
// compared against a whole-board reference model.
module tb_board_diff;
  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         ready_in = 1'b1;
  logic [161:0] board_in = '0;
  logic         move_valid, frame_err, overrun;
  logic [3:0]   move_row, move_col;
  logic [1:0]   move_color;
  logic [6:0]   change_count;
  logic [161:0] board_out;

  board_diff dut (
    .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in), .board_in(board_in),
    .move_valid(move_valid), .move_row(move_row), .move_col(move_col),
    .move_color(move_color), .change_count(change_count), .frame_err(frame_err),
    .overrun(overrun), .board_out(board_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0, n_bad = 0;

  // reference state: accepted board and last reported values
  logic [161:0] m_prev;
  logic [3:0]   m_row, m_col;
  logic [1:0]   m_color;
  logic [6:0]   m_cnt;
  logic         m_err;

  task automatic chk(input string tag, input logic [161:0] got, input logic [161:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset;
    m_prev = '0; m_row = '0; m_col = '0; m_color = '0; m_cnt = '0; m_err = 1'b0;
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, ".change_count"}, change_count, m_cnt);
    chk({tag, ".frame_err"}, frame_err, m_err);
    chk({tag, ".move_row"}, move_row, m_row);
    chk({tag, ".move_col"}, move_col, m_col);
    chk({tag, ".move_color"}, move_color, m_color);
    chk({tag, ".board_out"}, board_out, m_prev);
  endtask

  function automatic logic [161:0] set_cell(input logic [161:0] b, input int i, input logic [1:0] v);
    logic [161:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // Edge at cycle 0; optional second edge at ovr_at, optional reset at rst_at (0 = none).
  task automatic run_frame(input string tag, input logic [161:0] b, input int ovr_at, input int rst_at);
    int chg = 0, add = 0;
    logic e = 1'b0, early = 1'b0, ovr_bad = 1'b0, mv;
    logic [3:0] r = '0, c = '0;
    logic [1:0] col = '0, pc, cc;
    for (int i = 0; i < 81; i++) begin
      pc = m_prev[2*i +: 2];
      cc = b[2*i +: 2];
      if (cc != pc) chg++;
      if (pc == 2'b00 && cc != 2'b00 && cc != 2'b11) begin
        add++; r = 4'(i / 9); c = 4'(i % 9); col = cc;
      end
      if (cc == 2'b11) e = 1'b1;
    end
    mv = !e && add == 1;

    ready_in = 1'b0; tick;
    ready_in = 1'b1; board_in = b; tick;
    board_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int cyc = 1; cyc <= 82; cyc++) begin
      if (move_valid) early = 1'b1;
      if (overrun !== (ovr_at > 0 && cyc == ovr_at + 1)) ovr_bad = 1'b1;
      if (ovr_at > 0 && cyc == ovr_at - 1) ready_in = 1'b0;
      if (ovr_at > 0 && cyc == ovr_at) ready_in = 1'b1;
      if (rst_at > 0 && cyc == rst_at) begin
        rst_in = 1'b1; tick; rst_in = 1'b0;
        model_reset();
        for (int k = 0; k < 90; k++) begin
          if (move_valid || overrun) early = 1'b1;
          tick;
        end
        chk({tag, ".no_pulse_after_rst"}, early, 1'b0);
        chk_hold(tag);
        return;
      end
      tick;
    end
    chk({tag, ".no_early_pulse"}, early, 1'b0);
    chk({tag, ".overrun_timing"}, ovr_bad, 1'b0);
    m_cnt = 7'(chg);
    m_err = e;
    if (!e) m_prev = b;
    if (mv) begin m_row = r; m_col = c; m_color = col; end
    chk({tag, ".move_valid"}, move_valid, mv);
    chk_hold(tag);
    tick;
    chk({tag, ".pulse_end"}, move_valid, 1'b0);
    for (int k = 0; k < 4; k++) tick;
    chk({tag, ".idle_quiet"}, move_valid | overrun, 1'b0);
    chk({tag, ".board_held"}, board_out, m_prev);
  endtask

  initial begin
    logic [161:0] b, b_pre;
    logic pulse;
    int n, ovr;
    model_reset();
    // reset with ready_in held high must not start a scan
    rst_in = 1'b1; ready_in = 1'b1;
    tick; tick;
    rst_in = 1'b0;
    pulse = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (move_valid || overrun) pulse = 1'b1;
      tick;
    end
    chk("rst.no_pulse", pulse, 1'b0);
    chk_hold("rst");

    b = set_cell('0, 40, 2'b01);
    run_frame("first_move", b, 0, 0);
    b = set_cell(set_cell(b, 40, 2'b00), 80, 2'b10);
    run_frame("move_and_remove", b, 0, 0);
    b_pre = b;
    b = set_cell(set_cell(b_pre, 0, 2'b11), 5, 2'b01);
    run_frame("bad_frame", b, 0, 0);
    b = set_cell(b_pre, 5, 2'b01);
    run_frame("after_bad", b, 0, 0);
    b = set_cell(set_cell(b, 1, 2'b01), 9, 2'b10);
    run_frame("two_stones", b, 0, 0);
    b = set_cell(b, 20, 2'b10);
    run_frame("overrun", b, 40, 0);
    b = set_cell(b, 33, 2'b01);
    run_frame("mid_reset", b, 0, 30);
    b = set_cell('0, 72, 2'b01);
    run_frame("post_reset", b, 0, 0);

    for (int t = 0; t < 25; t++) begin
      b = m_prev;
      if ($urandom_range(0, 7) == 0) begin
        b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          b = set_cell(b, $urandom_range(0, 80), 2'($urandom_range(0, 2)));
        if ($urandom_range(0, 7) == 0) b = set_cell(b, $urandom_range(0, 80), 2'b11);
      end
      ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 80) : 0;
      run_frame("random", b, ovr, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
